// File: rtl/whack_player_ctrl.sv
// Per-player whack-a-mole controller: spawn, collision avoidance, tiered scoring.
// Optional: define WHACK_MISS_PENALTY_EN to deduct PENALTY on wrong presses and timeouts.
module whack_player_ctrl #(
    parameter int NUM_HOLES  = 9,
    parameter int POS_W      = 4,
    parameter int DELAY_W    = 27,
    parameter int BASE_DELAY = 25_000_000,
    parameter int UP_TIME    = 75_000_000,
    parameter int SCORE_W    = 16,
    parameter int CNT_W      = 8,
    parameter int PTS_FAST   = 200,
    parameter int PTS_MID    = 100,
    parameter int PTS_SLOW   = 50,
    parameter int PENALTY    = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_HOLES-1:0] buttons,
    input  logic [POS_W-1:0]     other_pos,
    input  logic                 other_pos_vld,
    input  logic [POS_W-1:0]     other_next,
    input  logic                 other_next_vld,
    input  logic [POS_W-1:0]     rand_pos,
    input  logic [DELAY_W-1:0]   random_delay,
    output logic [POS_W-1:0]     my_pos,
    output logic                 my_pos_vld,
    output logic [POS_W-1:0]     next_pos,
    output logic                 next_pos_vld,
    output logic [SCORE_W-1:0]   score,
    output logic [CNT_W-1:0]     hits,
    output logic [CNT_W-1:0]     misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    typedef enum logic [1:0] {
        S_IDLE, S_ARM, S_WAIT, S_UP
    } state_t;

    localparam int T1 = (2 * UP_TIME) / 3;
    localparam int T2 = UP_TIME / 3;

    if (NUM_HOLES < 2 || NUM_HOLES > 16 || (2 ** POS_W) < NUM_HOLES) begin : g_bad_holes
        $error("whack_player_ctrl: bad NUM_HOLES/POS_W");
    end
    if (UP_TIME < 3) begin : g_bad_up
        $error("whack_player_ctrl: UP_TIME must be >= 3");
    end
    if (PENALTY < 0 || PENALTY >= (2 ** SCORE_W)) begin : g_bad_pen
        $error("whack_player_ctrl: PENALTY out of range");
    end

    state_t               state_q, state_d;
    logic [NUM_HOLES-1:0] btn_q;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [DELAY_W-1:0]   timer_q, timer_d;
    logic [POS_W-1:0]     my_pos_q, my_pos_d;
    logic                 my_vld_q, my_vld_d;
    logic [POS_W-1:0]     nxt_q, nxt_d;
    logic                 nxt_vld_q, nxt_vld_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]     hits_q, hits_d;
    logic [CNT_W-1:0]     misses_q, misses_d;
    logic                 hit_p_q, hit_p_d;
    logic                 miss_p_q, miss_p_d;

    logic [NUM_HOLES-1:0] press, sel;
    logic                 hit, collide;
    logic [SCORE_W-1:0]   pts;
    logic [SCORE_W:0]     sum;
`ifdef WHACK_MISS_PENALTY_EN
    logic                 wrong;
    logic [SCORE_W-1:0]   score_pen;
`endif

    assign press   = buttons & ~btn_q;
    assign sel     = NUM_HOLES'(1) << my_pos_q;
    assign hit     = |(press & sel);
    assign collide = (other_pos_vld && other_pos == nxt_q)
                  || (other_next_vld && other_next == nxt_q);
    assign sum     = {1'b0, score_q} + {1'b0, pts};
`ifdef WHACK_MISS_PENALTY_EN
    assign wrong     = |(press & ~sel);
    assign score_pen = (score_q < SCORE_W'(PENALTY)) ? '0
                     : score_q - SCORE_W'(PENALTY);
`endif

    always_comb begin
        pts = SCORE_W'(PTS_SLOW);
        if (timer_q >= DELAY_W'(T1)) begin
            pts = SCORE_W'(PTS_FAST);
        end else if (timer_q >= DELAY_W'(T2)) begin
            pts = SCORE_W'(PTS_MID);
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        timer_d   = timer_q;
        my_pos_d  = my_pos_q;
        my_vld_d  = my_vld_q;
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
        score_d   = score_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        hit_p_d   = 1'b0;
        miss_p_d  = 1'b0;
        if (!enable) begin
            state_d   = S_IDLE;
            my_vld_d  = 1'b0;
            nxt_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    my_vld_d  = 1'b0;
                    nxt_vld_d = 1'b0;
                    state_d   = S_ARM;
                end
                S_ARM: begin
                    nxt_d     = POS_W'(32'(rand_pos) % NUM_HOLES);
                    nxt_vld_d = 1'b1;
                    delay_d   = DELAY_W'(BASE_DELAY) + random_delay;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    if (collide) begin
                        nxt_d = (nxt_q == POS_W'(NUM_HOLES - 1)) ? '0
                              : nxt_q + POS_W'(1);
                    end
                    if (delay_q != '0) begin
                        delay_d = delay_q - DELAY_W'(1);
                    end else if (!collide) begin
                        my_pos_d  = nxt_q;
                        my_vld_d  = 1'b1;
                        nxt_vld_d = 1'b0;
                        timer_d   = DELAY_W'(UP_TIME - 1);
                        state_d   = S_UP;
                    end
                end
                S_UP: begin
                    // A correct press always wins, even on the last cycle
                    if (hit) begin
                        score_d  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                        hits_d   = (hits_q == '1) ? hits_q : hits_q + CNT_W'(1);
                        hit_p_d  = 1'b1;
                        my_vld_d = 1'b0;
                        state_d  = S_ARM;
                    end else if (timer_q == '0) begin
                        misses_d = (misses_q == '1) ? misses_q
                                 : misses_q + CNT_W'(1);
                        miss_p_d = 1'b1;
                        my_vld_d = 1'b0;
                        state_d  = S_ARM;
`ifdef WHACK_MISS_PENALTY_EN
                        score_d  = score_pen;
`endif
                    end else begin
                        timer_d = timer_q - DELAY_W'(1);
`ifdef WHACK_MISS_PENALTY_EN
                        if (wrong) begin
                            score_d = score_pen;
                        end
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            btn_q     <= '0;
            delay_q   <= '0;
            timer_q   <= '0;
            my_pos_q  <= '0;
            my_vld_q  <= 1'b0;
            nxt_q     <= '0;
            nxt_vld_q <= 1'b0;
            score_q   <= '0;
            hits_q    <= '0;
            misses_q  <= '0;
            hit_p_q   <= 1'b0;
            miss_p_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= buttons;
            delay_q   <= delay_d;
            timer_q   <= timer_d;
            my_pos_q  <= my_pos_d;
            my_vld_q  <= my_vld_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
            score_q   <= score_d;
            hits_q    <= hits_d;
            misses_q  <= misses_d;
            hit_p_q   <= hit_p_d;
            miss_p_q  <= miss_p_d;
        end
    end

    assign my_pos       = my_pos_q;
    assign my_pos_vld   = my_vld_q;
    assign next_pos     = nxt_q;
    assign next_pos_vld = nxt_vld_q;
    assign score        = score_q;
    assign hits         = hits_q;
    assign misses       = misses_q;
    assign hit_pulse    = hit_p_q;
    assign miss_pulse   = miss_p_q;

endmodule

// File: tb/tb_whack_player_ctrl.sv
// Directed bench for whack_player_ctrl: spawn timing, tiers, collisions,
// held buttons, timeouts, disable and async reset.
module tb_whack_player_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [8:0]  buttons;
    logic [3:0]  other_pos;
    logic        other_pos_vld;
    logic [3:0]  other_next;
    logic        other_next_vld;
    logic [3:0]  rand_pos;
    logic [26:0] random_delay;
    logic [3:0]  my_pos;
    logic        my_pos_vld;
    logic [3:0]  next_pos;
    logic        next_pos_vld;
    logic [15:0] score;
    logic [7:0]  hits;
    logic [7:0]  misses;
    logic        hit_pulse;
    logic        miss_pulse;

    int n_assert;
    int n_fail;

`ifdef WHACK_MISS_PENALTY_EN
    localparam int SCORE_AFTER_MISS = 525;
`else
    localparam int SCORE_AFTER_MISS = 550;
`endif

    whack_player_ctrl #(
        .NUM_HOLES(9), .POS_W(4), .DELAY_W(27),
        .BASE_DELAY(4), .UP_TIME(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .buttons(buttons),
        .other_pos(other_pos), .other_pos_vld(other_pos_vld),
        .other_next(other_next), .other_next_vld(other_next_vld),
        .rand_pos(rand_pos), .random_delay(random_delay),
        .my_pos(my_pos), .my_pos_vld(my_pos_vld),
        .next_pos(next_pos), .next_pos_vld(next_pos_vld),
        .score(score), .hits(hits), .misses(misses),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_my_pos"}, 32'(my_pos), 32'd0);
        check({pfx, "_my_vld"}, 32'(my_pos_vld), 32'd0);
        check({pfx, "_next_pos"}, 32'(next_pos), 32'd0);
        check({pfx, "_next_vld"}, 32'(next_pos_vld), 32'd0);
        check({pfx, "_score"}, 32'(score), 32'd0);
        check({pfx, "_hits"}, 32'(hits), 32'd0);
        check({pfx, "_misses"}, 32'(misses), 32'd0);
        check({pfx, "_hit_p"}, 32'(hit_pulse), 32'd0);
        check({pfx, "_miss_p"}, 32'(miss_pulse), 32'd0);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        buttons        = '0;
        other_pos      = '0;
        other_pos_vld  = 1'b0;
        other_next     = '0;
        other_next_vld = 1'b0;
        rand_pos       = '0;
        random_delay   = '0;
        tick(3);
        check_zero("rst");

        // Spawn: ARM entered, mole up 6 edges later
        rst_n    = 1'b1;
        rand_pos = 4'd3;
        enable   = 1'b1;
        tick(1);
        tick(1);
        check("arm_next_pos", 32'(next_pos), 32'd3);
        check("arm_next_vld", 32'(next_pos_vld), 32'd1);
        tick(4);
        check("wait_vld_low", 32'(my_pos_vld), 32'd0);
        check("wait_next_vld", 32'(next_pos_vld), 32'd1);
        tick(1);
        check("spawn_pos", 32'(my_pos), 32'd3);
        check("spawn_vld", 32'(my_pos_vld), 32'd1);
        check("spawn_next_vld", 32'(next_pos_vld), 32'd0);

        // Fast hit at timer=11
        buttons[3] = 1'b1;
        tick(1);
        check("fast_score", 32'(score), 32'd200);
        check("fast_hits", 32'(hits), 32'd1);
        check("fast_pulse", 32'(hit_pulse), 32'd1);
        check("fast_vld", 32'(my_pos_vld), 32'd0);
        buttons = '0;
        tick(1);
        check("pulse_one_cycle", 32'(hit_pulse), 32'd0);

        // Mid hit at timer=5
        tick(5);
        check("mole2_vld", 32'(my_pos_vld), 32'd1);
        tick(6);
        buttons[3] = 1'b1;
        tick(1);
        check("mid_score", 32'(score), 32'd300);
        buttons = '0;

        // Slow hit on the timer==0 cycle
        tick(6);
        check("mole3_vld", 32'(my_pos_vld), 32'd1);
        tick(11);
        buttons[3] = 1'b1;
        tick(1);
        check("slow_score", 32'(score), 32'd350);
        check("slow_hits", 32'(hits), 32'd3);
        check("slow_misses", 32'(misses), 32'd0);
        check("slow_hit_p", 32'(hit_pulse), 32'd1);
        check("slow_miss_p", 32'(miss_pulse), 32'd0);
        buttons = '0;

        // Collision walk 8 -> 0 -> 1
        rand_pos       = 4'd8;
        other_pos      = 4'd8;
        other_pos_vld  = 1'b1;
        other_next     = 4'd0;
        other_next_vld = 1'b1;
        tick(1);
        check("col_next_8", 32'(next_pos), 32'd8);
        tick(1);
        check("col_next_0", 32'(next_pos), 32'd0);
        tick(1);
        check("col_next_1", 32'(next_pos), 32'd1);
        tick(2);
        check("col_vld_low", 32'(my_pos_vld), 32'd0);
        tick(1);
        check("col_pos", 32'(my_pos), 32'd1);
        check("col_vld", 32'(my_pos_vld), 32'd1);
        other_pos_vld  = 1'b0;
        other_next_vld = 1'b0;
        buttons[1]     = 1'b1;
        tick(1);
        check("col_hit_score", 32'(score), 32'd550);
        check("col_hit_hits", 32'(hits), 32'd4);
        buttons = '0;

        // Held button: no hit, timeout after 12 UP cycles
        rand_pos   = 4'd3;
        buttons[3] = 1'b1;
        tick(6);
        check("held_spawn", 32'(my_pos_vld), 32'd1);
        tick(11);
        check("held_still_up", 32'(my_pos_vld), 32'd1);
        check("held_no_hit", 32'(hits), 32'd4);
        check("held_no_miss", 32'(misses), 32'd0);
        tick(1);
        check("miss_pulse", 32'(miss_pulse), 32'd1);
        check("miss_count", 32'(misses), 32'd1);
        check("miss_vld", 32'(my_pos_vld), 32'd0);
        check("miss_score", 32'(score), 32'(SCORE_AFTER_MISS));
        tick(1);
        check("miss_pulse_end", 32'(miss_pulse), 32'd0);
        buttons = '0;

        // Disable during WAIT
        check("pre_dis_next_vld", 32'(next_pos_vld), 32'd1);
        enable = 1'b0;
        tick(1);
        check("dis_next_vld", 32'(next_pos_vld), 32'd0);
        check("dis_my_vld", 32'(my_pos_vld), 32'd0);
        check("dis_score", 32'(score), 32'(SCORE_AFTER_MISS));
        check("dis_hits", 32'(hits), 32'd4);
        tick(2);
        check("idle_next_vld", 32'(next_pos_vld), 32'd0);
        enable = 1'b1;
        tick(1);
        tick(6);
        check("reen_spawn", 32'(my_pos_vld), 32'd1);

        // Async reset during UP
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        enable = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

`ifdef WHACK_MISS_PENALTY_EN
        enable = 1'b1;
        tick(1);
        tick(6);
        check("pen_spawn", 32'(my_pos_vld), 32'd1);
        buttons[5] = 1'b1;
        tick(1);
        check("pen_sat0", 32'(score), 32'd0);
        check("pen_still_up", 32'(my_pos_vld), 32'd1);
        buttons    = '0;
        buttons[3] = 1'b1;
        tick(1);
        check("pen_fast", 32'(score), 32'd200);
        buttons = '0;
        tick(6);
        tick(12);
        check("pen_timeout", 32'(score), 32'd175);
        check("pen_misses", 32'(misses), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
